// File: rtl/mem_resp_pkg.sv
// +----------------------------------------------------------------------+
// | mem_resp_pkg                                                         |
// | Shared constants, response pipeline stage type and LFSR step helper  |
// | for the memory responder.                                            |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`include "config.svh"
`default_nettype none

package mem_resp_pkg;

  localparam int          XLEN        = `XLEN;
  localparam int          MAX_LATENCY = 4;

  // Stall generator: 16-bit Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10).
  localparam logic [15:0] LFSR_SEED   = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;

  // One slot of the in-flight response pipeline.
  typedef struct packed {
    logic            valid;
    logic            is_read;
    logic [XLEN-1:0] rdata;
  } resp_stage_t;

  // Shift left, feeding the XOR of the tapped bits into bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/config.svh
// +----------------------------------------------------------------------+
// | config.svh                                                           |
// | Build-wide configuration shared by the memory responder files.       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`ifndef MEM_RESP_CONFIG_SVH
`define MEM_RESP_CONFIG_SVH

// Data path width in bits; byte strobes are XLEN/8 wide.
`define XLEN 32

`endif

// File: rtl/mem_resp_lfsr.sv
// +----------------------------------------------------------------------+
// | mem_resp_lfsr                                                        |
// | Free-running 16-bit Fibonacci LFSR used to inject request stalls.    |
// | Reloads its seed while reset is asserted.                            |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_resp_lfsr
  import mem_resp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_b,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next LFSR value; advances every cycle out of reset.
  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
  end

  // LFSR state register, seeded on reset.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// +----------------------------------------------------------------------+
// | mem_responder                                                        |
// | Single-port word memory answering an addr_ok/data_ok request bus.    |
// | Every accepted request returns one data_ok pulse LATENCY cycles      |
// | later, in order. Define MEM_RESP_STALL_EN to add LFSR-driven stalls  |
// | on ram_addr_ok.                                                      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH   = 4096,  // words, power of 2
  parameter int LATENCY = 1      // 1..MAX_LATENCY
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              ram_req,
  input  logic              ram_write,
  input  logic [XLEN/8-1:0] ram_wstrb,
  input  logic [XLEN-1:0]   ram_addr,
  input  logic [XLEN-1:0]   ram_wdata,
  output logic              ram_addr_ok,
  output logic              ram_data_ok,
  output logic [XLEN-1:0]   ram_rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = XLEN / 8;

  logic [XLEN-1:0] mem_q [DEPTH];
  resp_stage_t     pipe_q [LATENCY];
  resp_stage_t     pipe_d [LATENCY];
  logic            ready_q;
  logic            stall;
  logic            accept;
  logic            rd_accept;
  logic [AW-1:0]   idx;
  logic            unused_addr;

  // Byte offset and the bits above the array range are ignored (aliasing).
  assign idx         = ram_addr[AW+1:2];
  assign unused_addr = ^ram_addr;

`ifdef MEM_RESP_STALL_EN
  logic [15:0] lfsr;
  logic        unused_lfsr;

  mem_resp_lfsr u_lfsr (
    .clk    (clk),
    .rst_b  (rst_b),
    .lfsr_o (lfsr)
  );

  assign stall       = (lfsr[1:0] == 2'b00);
  assign unused_lfsr = ^lfsr[15:2];
`else
  assign stall = 1'b0;
`endif

  assign ram_addr_ok = ready_q & ~stall;
  assign accept      = ram_req & ram_addr_ok;
  assign rd_accept   = accept & ~ram_write;

  // Holds addr_ok low through reset and the first post-reset cycle.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

  // Byte-strobed array write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (accept && ram_write) begin
      for (int b = 0; b < NB; b++) begin
        if (ram_wstrb[b]) begin
          mem_q[idx][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
      end
    end
  end

  // Stage 0 captures the request (read data sampled now); later stages shift.
  always_comb begin
    pipe_d[0].valid   = accept;
    pipe_d[0].is_read = rd_accept;
    pipe_d[0].rdata   = rd_accept ? mem_q[idx] : '0;
    for (int s = 1; s < LATENCY; s++) begin
      pipe_d[s] = pipe_q[s-1];
    end
  end

  // Response pipeline; reset drops everything in flight.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int s = 0; s < LATENCY; s++) begin
        pipe_q[s] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign ram_data_ok = pipe_q[LATENCY-1].valid;
  assign ram_rdata   = (pipe_q[LATENCY-1].valid && pipe_q[LATENCY-1].is_read)
                       ? pipe_q[LATENCY-1].rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// +----------------------------------------------------------------------+
// | tb_mem_responder                                                     |
// | Directed bench driving three responders (LATENCY 1, 2, 3) with the   |
// | same request stream; expected responses come from hand-given data   |
// | scheduled LATENCY cycles after each accept.                          |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_responder;
  import mem_resp_pkg::*;

  localparam int NDUT = 3;
  localparam int HIST = 2048;

  logic              clk = 1'b0;
  logic              rst_b;
  logic              ram_req;
  logic              ram_write;
  logic [XLEN/8-1:0] ram_wstrb;
  logic [XLEN-1:0]   ram_addr;
  logic [XLEN-1:0]   ram_wdata;
  logic [NDUT-1:0]   aok;
  logic [NDUT-1:0]   dok;
  logic [XLEN-1:0]   rdat [NDUT];

  int                checks;
  int                failures;
  int                cyc;
  bit                exp_v [HIST];
  logic [XLEN-1:0]   exp_d [HIST];
  bit                m_ready;
  logic [15:0]       m_lfsr;
  int                n_dok [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mem_responder #(.DEPTH(4096), .LATENCY(g + 1)) u_dut (
      .clk         (clk),
      .rst_b       (rst_b),
      .ram_req     (ram_req),
      .ram_write   (ram_write),
      .ram_wstrb   (ram_wstrb),
      .ram_addr    (ram_addr),
      .ram_wdata   (ram_wdata),
      .ram_addr_ok (aok[g]),
      .ram_data_ok (dok[g]),
      .ram_rdata   (rdat[g])
    );
  end

  // Count delivered responses per instance.
  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (dok[i] === 1'b1) n_dok[i]++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", tag, cyc, act, exp);
    end
  endtask

  function automatic bit exp_aok();
`ifdef MEM_RESP_STALL_EN
    return m_ready && (m_lfsr[1:0] != 2'b00);
`else
    return m_ready;
`endif
  endfunction

  // Advance one clock, update the reference state, check every instance.
  task automatic step();
    bit rst_at_edge;
    rst_at_edge = rst_b;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= HIST) begin
      $display("FAIL history_overflow cycle=%0d", cyc);
      $fatal(1, "history overflow");
    end
    if (rst_at_edge) begin
      m_ready = 1'b1;
      m_lfsr  = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
    for (int i = 0; i < NDUT; i++) begin
      bit              ev;
      logic [XLEN-1:0] ed;
      ev = (cyc >= i + 1) ? exp_v[cyc-(i+1)] : 1'b0;
      ed = ev ? exp_d[cyc-(i+1)] : '0;
      check_eq($sformatf("L%0d_data_ok", i + 1), {31'd0, dok[i]}, {31'd0, ev});
      check_eq($sformatf("L%0d_rdata", i + 1), rdat[i], ed);
      check_eq($sformatf("L%0d_addr_ok", i + 1), {31'd0, aok[i]}, {31'd0, exp_aok()});
    end
  endtask

  // One cycle with ram_req high; acc reports whether it should be accepted.
  task automatic cycle_req(input bit wr, input logic [3:0] strb, input logic [XLEN-1:0] addr,
                           input logic [XLEN-1:0] wd, input logic [XLEN-1:0] erd, output bit acc);
    ram_req   = 1'b1;
    ram_write = wr;
    ram_wstrb = strb;
    ram_addr  = addr;
    ram_wdata = wd;
    acc       = exp_aok();
    if (acc) begin
      exp_v[cyc] = 1'b1;
      exp_d[cyc] = wr ? '0 : erd;
    end
    step();
    ram_req = 1'b0;
  endtask

  // Hold a request until accepted (bounded).
  task automatic req(input bit wr, input logic [3:0] strb, input logic [XLEN-1:0] addr,
                     input logic [XLEN-1:0] wd, input logic [XLEN-1:0] erd);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 32) begin
      cycle_req(wr, strb, addr, wd, erd, acc);
      n++;
    end
    check_eq("req_accepted", {31'd0, acc}, 32'd1);
  endtask

  task automatic idle(input int n);
    ram_req = 1'b0;
    repeat (n) step();
  endtask

  task automatic assert_reset();
    rst_b   = 1'b0;
    m_ready = 1'b0;
    m_lfsr  = LFSR_SEED;
    foreach (exp_v[k]) exp_v[k] = 1'b0;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check_eq($sformatf("L%0d_rst_addr_ok", i + 1), {31'd0, aok[i]}, 32'd0);
      check_eq($sformatf("L%0d_rst_data_ok", i + 1), {31'd0, dok[i]}, 32'd0);
      check_eq($sformatf("L%0d_rst_rdata", i + 1), rdat[i], 32'd0);
    end
  endtask

  task automatic release_reset();
    rst_b = 1'b1;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check_eq($sformatf("L%0d_addr_ok_pre_edge", i + 1), {31'd0, aok[i]}, 32'd0);
    end
  endtask

  initial begin
    int start_dok [NDUT];
    int accepts;
    bit acc;

    checks    = 0;
    failures  = 0;
    cyc       = 0;
    ram_req   = 1'b0;
    ram_write = 1'b0;
    ram_wstrb = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    foreach (n_dok[i]) n_dok[i] = 0;

    // Power-on reset, then release: addr_ok rises one edge later.
    assert_reset();
    idle(2);
    release_reset();
    idle(1);

    // Full-word write then read of the same word in the next cycle.
    req(1'b1, 4'hF, 32'h0000_0100, 32'h1234_5678, '0);
    req(1'b0, 4'h0, 32'h0000_0100, '0, 32'h1234_5678);
    idle(4);

    // Partial byte-strobe merge.
    req(1'b1, 4'hF, 32'h0000_0200, 32'h1111_1111, '0);
    req(1'b1, 4'b0101, 32'h0000_0200, 32'hAABB_CCDD, '0);
    req(1'b0, 4'h0, 32'h0000_0200, '0, 32'h11BB_11DD);
    idle(4);

    // Address aliasing above the array range.
    req(1'b1, 4'hF, 32'h0000_4004, 32'hCAFE_F00D, '0);
    req(1'b0, 4'h0, 32'h0000_0004, '0, 32'hCAFE_F00D);
    idle(4);

    // Back-to-back reads, low address bits ignored on the last one.
    req(1'b0, 4'h0, 32'h0000_0100, '0, 32'h1234_5678);
    req(1'b0, 4'h0, 32'h0000_0200, '0, 32'h11BB_11DD);
    req(1'b0, 4'h0, 32'h0000_4004, '0, 32'hCAFE_F00D);
    req(1'b0, 4'h0, 32'h0000_0103, '0, 32'h1234_5678);
    idle(5);

    // A write presented without ram_req must leave memory untouched.
    ram_req   = 1'b0;
    ram_write = 1'b1;
    ram_wstrb = 4'hF;
    ram_addr  = 32'h0000_0100;
    ram_wdata = 32'hDEAD_BEEF;
    step();
    req(1'b0, 4'h0, 32'h0000_0100, '0, 32'h1234_5678);
    idle(4);

    // Reset one cycle after a read accept discards it; memory is retained.
    req(1'b0, 4'h0, 32'h0000_0200, '0, 32'h11BB_11DD);
    assert_reset();
    idle(2);
    release_reset();
    idle(1);
    req(1'b0, 4'h0, 32'h0000_0100, '0, 32'h1234_5678);
    req(1'b0, 4'h0, 32'h0000_0200, '0, 32'h11BB_11DD);
    req(1'b0, 4'h0, 32'h0000_0004, '0, 32'hCAFE_F00D);
    idle(5);

    // Request held high for 1000 cycles: every accept yields one data_ok.
    foreach (start_dok[i]) start_dok[i] = n_dok[i];
    accepts = 0;
    for (int c = 0; c < 1000; c++) begin
      cycle_req(1'b0, 4'h0, 32'h0000_0100, '0, 32'h1234_5678, acc);
      if (acc) accepts++;
    end
    idle(5);
    for (int i = 0; i < NDUT; i++) begin
      check_eq($sformatf("L%0d_dok_count", i + 1), n_dok[i] - start_dok[i], accepts);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 4096, SHALL set the storage size in XLEN-bit words; it must be a power of 2.
REQ-002 Parameter LATENCY, default 1, SHALL set the cycles from request acceptance to data_ok; legal range is 1..4.
REQ-003 Port clk, input, 1: the single clock.
REQ-004 Port rst_b, input, 1: asynchronous, active-low reset.
REQ-005 Port ram_req, input, 1: initiator request valid.
REQ-006 Port ram_write, input, 1: 1 = write, 0 = read.
REQ-007 Port ram_wstrb, input, XLEN/8: byte write strobes.
REQ-008 Port ram_addr, input, XLEN: byte address.
REQ-009 Port ram_wdata, input, XLEN: write data.
REQ-010 Port ram_addr_ok, output, 1: request accepted this cycle when ram_req is also 1.
REQ-011 Port ram_data_ok, output, 1: one-cycle pulse completing the oldest accepted request.
REQ-012 Port ram_rdata, output, XLEN: read data, valid only while ram_data_ok=1 for a read.

Function
REQ-013 A request SHALL be accepted in exactly the cycles where ram_req=1 and ram_addr_ok=1; at most one is accepted per cycle.
REQ-014 Word index SHALL be ram_addr[log2(DEPTH)+1:2]; low 2 bits are ignored; higher bits alias (wrap).
REQ-015 An accepted write SHALL update only the bytes whose ram_wstrb bit is 1, at the clock edge ending the accept cycle.
REQ-016 An accepted read SHALL sample the array in the accept cycle, so a write accepted in cycle N is visible to a read accepted in N+1.
REQ-017 Every accepted request, read or write, SHALL produce exactly one ram_data_ok pulse exactly LATENCY cycles after the accept edge, in acceptance order.
REQ-018 In-flight responses SHALL travel through a LATENCY-deep valid/rdata/is_read shift pipeline; back-to-back accepts SHALL give back-to-back data_ok pulses.
REQ-019 ram_data_ok SHALL NOT be back-pressured; the initiator must always consume it.
REQ-020 ram_rdata SHALL be 0 whenever ram_data_ok=0 or the completing request is a write.
REQ-021 Without stall injection, ram_addr_ok SHALL be 1 in every cycle after the first post-reset cycle.
REQ-022 If ram_req is deasserted before acceptance, no state SHALL change.

Reset
REQ-023 While rst_b=0: ram_addr_ok=0, ram_data_ok=0, ram_rdata=0, and all pipeline valids are cleared.
REQ-024 ram_addr_ok SHALL rise on the first clock edge after rst_b deasserts; the stall LFSR SHALL reload its seed.
REQ-025 Reset asserted mid-operation SHALL discard in-flight responses with no data_ok; array contents are not reset and are retained.

Configuration
REQ-026 Macro MEM_RESP_STALL_EN, when defined, SHALL enable a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) advancing every cycle; ram_addr_ok=0 whenever lfsr[1:0]==2'b00.
REQ-027 When MEM_RESP_STALL_EN is undefined, no LFSR logic SHALL exist and ram_addr_ok follows REQ-021.

Structure
REQ-028 Package mem_resp_pkg SHALL hold MAX_LATENCY=4, the LFSR seed, the tap mask and the response pipeline stage struct (valid, is_read, rdata).
REQ-029 The LFSR SHALL be a sub-module named mem_resp_lfsr, instantiated only under MEM_RESP_STALL_EN.
REQ-030 XLEN SHALL come from config.svh.

Verification
REQ-031 LATENCY=1: write 0x12345678 to 0x100 with wstrb=4'hF, then read 0x100 the next cycle -> second data_ok carries 0x12345678, one cycle after its accept.
REQ-032 Write 0xAABBCCDD with wstrb=4'b0101 over 0x11111111 at 0x200, then read -> rdata=0x11BB11DD.
REQ-033 LATENCY=3: four consecutive reads accepted in cycles 10-13 -> data_ok high in cycles 13-16, data in order.
REQ-034 DEPTH=4096: write 0xCAFEF00D to 0x4004, read 0x0004 -> 0xCAFEF00D (alias wrap).
REQ-035 LATENCY=2: assert rst_b=0 one cycle after a read accept -> no data_ok; after reset, addr_ok=1 one edge later and memory contents are intact.
REQ-036 MEM_RESP_STALL_EN defined, ram_req held high for 1000 cycles -> addr_ok low in exactly the cycles the reference-model LFSR gives lfsr[1:0]==0, and the data_ok count equals the accept count.
